// File: rtl/vga_mode_sched.sv
// Frame-synchronous display-mode scheduler: defers mode changes to a V_sys rising
// edge and blanks the picture for BLANK_FRAMES full frames around each switch.
module vga_mode_sched #(
   parameter int MODE_NUM     = 4,
   parameter int MW           = 4,
   parameter int AUTO_FRAMES  = 120,
   parameter int BLANK_FRAMES = 2
) (
   input  logic          Clk_int,
   input  logic          Sys_Rst,
   input  logic [1:0]    key_down,
   input  logic          V_sys,
   output logic [MW-1:0] mode_sel,
   output logic          blank_en,
   output logic          auto_on,
   output logic          busy
);

   localparam int FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
   localparam int BW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;

   typedef enum logic [1:0] {
      SHOW    = 2'd0,
      WAIT_VS = 2'd1,
      BLANK   = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic            v_d;
   logic            fe;
   logic [FW-1:0]   fcnt, fcnt_nxt;
   logic [BW-1:0]   bcnt, bcnt_nxt;
   logic [MW-1:0]   pend, pend_nxt;
   logic [MW-1:0]   mode_nxt;
   logic            blank_nxt;
   logic            auto_nxt;
   logic            req;

   // v_d resets high so a V_sys already asserted at reset release is not an edge
   assign fe = V_sys & ~v_d;

   always_ff @(posedge Clk_int or posedge Sys_Rst) begin
      if (Sys_Rst) begin
         state    <= SHOW;
         v_d      <= 1'b1;
         fcnt     <= '0;
         bcnt     <= '0;
         pend     <= '0;
         mode_sel <= '0;
         blank_en <= 1'b0;
         auto_on  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         v_d      <= V_sys;
         fcnt     <= fcnt_nxt;
         bcnt     <= bcnt_nxt;
         pend     <= pend_nxt;
         mode_sel <= mode_nxt;
         blank_en <= blank_nxt;
         auto_on  <= auto_nxt;
         busy     <= (state_nxt != SHOW);
      end
   end

   always_comb begin
      state_nxt = state;
      fcnt_nxt  = fcnt;
      bcnt_nxt  = bcnt;
      pend_nxt  = pend;
      mode_nxt  = mode_sel;
      blank_nxt = blank_en;
      auto_nxt  = auto_on;
      req       = key_down[0] | (auto_on & fe & (fcnt == FW'(AUTO_FRAMES - 1)));

      unique case (state)
         SHOW: begin
            if (req) begin
               pend_nxt  = (mode_sel == MW'(MODE_NUM - 1)) ? '0 : mode_sel + 1'b1;
               fcnt_nxt  = '0;
               state_nxt = WAIT_VS;
            end else if (auto_on & fe) begin
               fcnt_nxt = fcnt + 1'b1;
            end
         end
         WAIT_VS: begin
            if (fe) begin
               mode_nxt  = pend;
               blank_nxt = 1'b1;
               bcnt_nxt  = '0;
               state_nxt = BLANK;
            end
         end
         BLANK: begin
            if (fe) begin
               if (bcnt == BW'(BLANK_FRAMES - 1)) begin
                  blank_nxt = 1'b0;
                  fcnt_nxt  = '0;
                  state_nxt = SHOW;
               end else begin
                  bcnt_nxt = bcnt + 1'b1;
               end
            end
         end
         default: state_nxt = SHOW;
      endcase

      // auto toggle acts in every state and never touches a change in flight
      if (key_down[1]) begin
         auto_nxt = ~auto_on;
         fcnt_nxt = '0;
      end
   end

endmodule
